// File: rtl/ahb_gpio_pkg.sv
// Shared constants for the AHB-Lite GPIO/interrupt controller: register map,
// debug scratch addresses, AHB encodings and the bank-width helper.
package ahb_gpio_pkg;

  localparam logic [2:0] REG_DATA_IN  = 3'd0;
  localparam logic [2:0] REG_DATA_OUT = 3'd1;
  localparam logic [2:0] REG_OEB      = 3'd2;
  localparam logic [2:0] REG_IRQ_EN   = 3'd3;
  localparam logic [2:0] REG_IRQ_TYPE = 3'd4;
  localparam logic [2:0] REG_IRQ_POL  = 3'd5;
  localparam logic [2:0] REG_STATUS   = 3'd6;
  localparam logic [2:0] REG_ID       = 3'd7;

  localparam logic [23:0] DBG_ADDR0 = 24'hFFFFF8;
  localparam logic [23:0] DBG_ADDR1 = 24'hFFFFFC;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic [31:0] DEFAULT_ID = 32'h4750_494F;

  // Number of real pins in a given 32-pin bank.
  function automatic int unsigned bank_width(input int unsigned n_pins, input int unsigned bank);
    int unsigned rem;
    rem = n_pins - 32 * bank;
    return (rem >= 32) ? 32 : rem;
  endfunction

endpackage

// File: rtl/ahb_gpio_bank.sv
// One bank of up to 32 GPIO pins: input synchroniser, event detection and the
// per-bank control/status registers. Pins beyond WIDTH simply do not exist.
module ahb_gpio_bank
  import ahb_gpio_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pad,
  input  logic             arm,
  input  logic             wr_en,
  input  logic [2:0]       reg_sel,
  input  logic [WIDTH-1:0] wr_data,
  output logic [31:0]      rd_data,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] oeb,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [WIDTH-1:0] out_q, oeb_q, en_q, type_q, pol_q, status_q, status_d;
  logic [WIDTH-1:0] rise, fall, edge_ev, level_ev, evt, w1c;

  always_comb begin
    rise     = sync2_q & ~prev_q;
    fall     = ~sync2_q & prev_q;
    edge_ev  = (pol_q & rise) | (~pol_q & fall);
    level_ev = ~(sync2_q ^ pol_q);
    evt      = (type_q & edge_ev & {WIDTH{arm}}) | (~type_q & level_ev);
    w1c      = (wr_en && reg_sel == REG_STATUS) ? wr_data : '0;
    // A new event in the same cycle as a clear keeps the bit set.
    status_d = (status_q & ~w1c) | evt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      out_q    <= '0;
      oeb_q    <= '1;
      en_q     <= '0;
      type_q   <= '0;
      pol_q    <= '0;
      status_q <= '0;
    end else begin
      sync1_q  <= pad;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      status_q <= status_d;
      if (wr_en) begin
        case (reg_sel)
          REG_DATA_OUT: out_q  <= wr_data;
          REG_OEB:      oeb_q  <= wr_data;
          REG_IRQ_EN:   en_q   <= wr_data;
          REG_IRQ_TYPE: type_q <= wr_data;
          REG_IRQ_POL:  pol_q  <= wr_data;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_DATA_IN:  rd_data[WIDTH-1:0] = sync2_q;
      REG_DATA_OUT: rd_data[WIDTH-1:0] = out_q;
      REG_OEB:      rd_data[WIDTH-1:0] = oeb_q;
      REG_IRQ_EN:   rd_data[WIDTH-1:0] = en_q;
      REG_IRQ_TYPE: rd_data[WIDTH-1:0] = type_q;
      REG_IRQ_POL:  rd_data[WIDTH-1:0] = pol_q;
      REG_STATUS:   rd_data[WIDTH-1:0] = status_q;
      default: ;
    endcase
  end

  assign data_out = out_q;
  assign oeb      = oeb_q;
  assign irq      = |(status_q & en_q);

endmodule

// File: rtl/ahb_gpio_irq_ctrl.sv
// AHB-Lite GPIO controller with per-pin interrupts: bus phase tracking, bank and
// debug decode, read mux, edge arming counter and the registered interrupt line.
module ahb_gpio_irq_ctrl
  import ahb_gpio_pkg::*;
#(
  parameter int unsigned N_PINS   = 38,
  parameter logic [31:0] ID_VALUE = DEFAULT_ID,
  parameter bit          DBG_EN   = 1'b1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  input  logic              HWRITE,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  input  logic [N_PINS-1:0] gpio_in,
  output logic [N_PINS-1:0] gpio_out,
  output logic [N_PINS-1:0] gpio_oeb,
  output logic              irq_o
);

  localparam int unsigned NB = (N_PINS + 31) / 32;

  logic             valid_q, write_q, irq_q;
  logic [2:0]       size_q;
  logic [21:0]      addr_q;
  logic [31:0]      scratch0_q, scratch1_q;
  logic [1:0]       arm_cnt_q;
  logic             addr_phase, wr_en, dbg0_hit, dbg1_hit, bank_space, arm;
  logic [23:0]      byte_addr;
  logic [2:0]       bank_idx, reg_sel;
  logic [NB-1:0]    bank_wr, bank_irq;
  logic [NB-1:0][31:0] bank_rdata;
  logic             unused_haddr;

  assign unused_haddr = ^{HADDR[31:24], HADDR[1:0]};

  assign addr_phase = HSEL & HREADY & (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign byte_addr  = {addr_q, 2'b00};
  assign dbg0_hit   = DBG_EN && (byte_addr == DBG_ADDR0);
  assign dbg1_hit   = DBG_EN && (byte_addr == DBG_ADDR1);
  assign bank_space = !dbg0_hit && !dbg1_hit && (byte_addr[23:8] == '0);
  assign bank_idx   = byte_addr[7:5];
  assign reg_sel    = byte_addr[4:2];
  assign wr_en      = valid_q & write_q & (size_q == HSIZE_WORD);
  // Edge events stay masked until the synchroniser has been clocked with real data.
  assign arm        = (arm_cnt_q == 2'd3);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      valid_q    <= 1'b0;
      write_q    <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      scratch0_q <= '0;
      scratch1_q <= '0;
      arm_cnt_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      valid_q <= addr_phase;
      if (addr_phase) begin
        addr_q  <= HADDR[23:2];
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
      if (wr_en && dbg0_hit) scratch0_q <= HWDATA;
      if (wr_en && dbg1_hit) scratch1_q <= HWDATA;
      if (!arm) arm_cnt_q <= arm_cnt_q + 2'd1;
      irq_q <= |bank_irq;
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    localparam int unsigned W = bank_width(N_PINS, b);

    assign bank_wr[b] = wr_en & bank_space & (bank_idx == 3'(b));

    ahb_gpio_bank #(
      .WIDTH(W)
    ) u_bank (
      .clk     (HCLK),
      .rst_n   (HRESETn),
      .pad     (gpio_in[32*b +: W]),
      .arm     (arm),
      .wr_en   (bank_wr[b]),
      .reg_sel (reg_sel),
      .wr_data (HWDATA[W-1:0]),
      .rd_data (bank_rdata[b]),
      .data_out(gpio_out[32*b +: W]),
      .oeb     (gpio_oeb[32*b +: W]),
      .irq     (bank_irq[b])
    );
  end

  always_comb begin
    HRDATA = '0;
    if (valid_q && !write_q) begin
      if (dbg0_hit) begin
        HRDATA = scratch0_q;
      end else if (dbg1_hit) begin
        HRDATA = scratch1_q;
      end else if (bank_space) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (bank_idx == 3'(b)) HRDATA = (reg_sel == REG_ID) ? ID_VALUE : bank_rdata[b];
        end
      end
    end
  end

  assign HREADYOUT = 1'b1;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_ahb_gpio_irq_ctrl.sv
// Directed bench for ahb_gpio_irq_ctrl: reads queue their expected data, and a
// data-phase monitor pops and compares it against HRDATA.
module tb_ahb_gpio_irq_ctrl;

  localparam int N = 38;

  logic        HCLK, HRESETn, HSEL, HREADY, HWRITE, HREADYOUT, irq_o;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [N-1:0] gpio_in, gpio_out, gpio_oeb;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        rd_dp = 1'b0;

  logic [31:0] exp_b0 [8] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0,
                              32'hFFFF_FFFF, 32'h4750_494F};
  logic [31:0] exp_b1 [8] = '{32'h0, 32'h0, 32'h0000_003F, 32'h0, 32'h0, 32'h0,
                              32'h0000_003F, 32'h4750_494F};

  ahb_gpio_irq_ctrl #(
    .N_PINS  (N),
    .ID_VALUE(32'h4750_494F),
    .DBG_EN  (1'b1)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HWDATA   (HWDATA),
    .HREADY   (HREADY),
    .HWRITE   (HWRITE),
    .HTRANS   (HTRANS),
    .HSIZE    (HSIZE),
    .HRDATA   (HRDATA),
    .HREADYOUT(HREADYOUT),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oeb (gpio_oeb),
    .irq_o    (irq_o)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Read data phase: compare HRDATA with the oldest queued expectation.
  always @(negedge HCLK) begin
    if (rd_dp) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL rd_queue: observed=empty expected=entry");
      end
      if (exp_q.size() != 0) check(tag_q.pop_front(), HRDATA, exp_q.pop_front());
      check("hreadyout", HREADYOUT, 1);
    end
  end

  task automatic bus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [2:0] size, input string tag);
    HSEL = 1'b1; HADDR = addr; HWRITE = wr; HTRANS = 2'b10; HSIZE = size;
    if (!wr) begin
      exp_q.push_back(data);
      tag_q.push_back(tag);
    end
    @(posedge HCLK); #1;
    rd_dp  = !wr;
    HWDATA = wr ? data : 32'h0;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus(1'b1, addr, data, 3'b010, "");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] want, input string tag);
    bus(1'b0, addr, want, 3'b010, tag);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge HCLK); #1;
      rd_dp = 1'b0;
    end
  endtask

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HREADY = 1'b1; HWRITE = 1'b0; HTRANS = 2'b00;
    HSIZE = 3'b010; HADDR = '0; HWDATA = '0; gpio_in = '0;
    idle(3);
    check("rst_hrdata", HRDATA, 0);
    check("rst_irq", irq_o, 0);
    check("rst_oeb", gpio_oeb, {N{1'b1}});
    check("rst_out", gpio_out, 0);
    HRESETn = 1'b1;

    // Post-reset register image; level-low default flags every low input.
    for (int r = 0; r < 8; r++) rd(32'(r * 4), exp_b0[r], $sformatf("rst_b0_r%0d", r));
    for (int r = 0; r < 8; r++) rd(32'(32 + r * 4), exp_b1[r], $sformatf("rst_b1_r%0d", r));
    idle(1);

    // Outputs and read-after-write.
    wr(32'h08, 32'h0);
    wr(32'h04, 32'hA5A5_A5A5);
    rd(32'h04, 32'hA5A5_A5A5, "raw_dout0");
    idle(1);
    check("pad_out0", gpio_out[31:0], 32'hA5A5_A5A5);
    check("pad_oeb0", gpio_oeb[31:0], 32'h0);
    check("pad_oeb1", gpio_oeb[37:32], 6'h3F);
    wr(32'h24, 32'hFFFF_FFFF);
    rd(32'h24, 32'h0000_003F, "dout1_mask");
    idle(1);
    check("pad_out1", gpio_out[37:32], 6'h3F);

    // Byte write ignored, debug scratch, unmapped bank.
    bus(1'b1, 32'h04, 32'h1234_5678, 3'b000, "");
    rd(32'h04, 32'hA5A5_A5A5, "byte_wr");
    wr(32'hFFFFF8, 32'hDEAD_BEEF);
    wr(32'hFFFFFC, 32'h1234_5678);
    rd(32'hFFFFF8, 32'hDEAD_BEEF, "scratch0");
    rd(32'hFFFFFC, 32'h1234_5678, "scratch1");
    rd(32'h68, 32'h0, "bank3_oeb");
    rd(32'h7C, 32'h0, "bank3_id");
    idle(1);

    // Rising-edge interrupt on pin 37 (bank 1 bit 5).
    gpio_in = '1;
    gpio_in[37] = 1'b0;
    idle(4);
    wr(32'h30, 32'h20);
    wr(32'h34, 32'h20);
    wr(32'h38, 32'h3F);
    wr(32'h18, 32'hFFFF_FFFF);
    wr(32'h2C, 32'h20);
    idle(2);
    rd(32'h38, 32'h0, "st1_clear");
    idle(1);
    check("irq_idle", irq_o, 0);
    gpio_in[37] = 1'b1;
    rd(32'h38, 32'h0, "st1_early");
    rd(32'h20, 32'h3F, "din1_sync");
    rd(32'h38, 32'h20, "st1_edge");
    check("irq_lag", irq_o, 0);
    idle(1);
    check("irq_set", irq_o, 1);
    wr(32'h38, 32'h20);
    idle(1);
    check("irq_hold", irq_o, 1);
    idle(1);
    check("irq_clr", irq_o, 0);
    rd(32'h38, 32'h0, "st1_w1c");
    idle(1);

    // Level-low pin 0 re-sets after W1C.
    gpio_in[0] = 1'b0;
    idle(4);
    rd(32'h18, 32'h1, "lvl_set");
    wr(32'h18, 32'h1);
    rd(32'h18, 32'h1, "lvl_reset");
    idle(1);

    // Rising edge on pin 3 lands in the same cycle as its W1C.
    wr(32'h10, 32'h8);
    wr(32'h14, 32'h8);
    idle(1);
    gpio_in[3] = 1'b0;
    idle(4);
    rd(32'h18, 32'h1, "fall_ignored");
    idle(1);
    gpio_in[3] = 1'b1;
    idle(1);
    wr(32'h18, 32'h8);
    rd(32'h18, 32'h9, "set_wins");
    idle(1);

    // Reset in a write data phase discards the write; inputs high across reset.
    gpio_in = '1;
    wr(32'h04, 32'hFFFF_FFFF);
    HRESETn = 1'b0;
    idle(1);
    check("rst_drop_out", gpio_out[31:0], 32'h0);
    check("rst_drop_oeb", gpio_oeb, {N{1'b1}});
    idle(1);
    HRESETn = 1'b1;
    wr(32'h10, 32'hFFFF_FFFF);
    wr(32'h14, 32'hFFFF_FFFF);
    wr(32'h18, 32'hFFFF_FFFF);
    idle(3);
    rd(32'h18, 32'h0, "arm_quiet");
    rd(32'h00, 32'hFFFF_FFFF, "din0_high");
    idle(2);
    check("irq_final", irq_o, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
